// File: rtl/scmi_db_pkg.sv
// Shared types for the SCMI doorbell event queue.
// Defining SCMI_DB_TIMESTAMP_EN adds a push timestamp to every queued event.
package scmi_db_pkg;

  localparam int NumChannelsDefault = 256;
  localparam int OvfCntWidth        = 8;
  localparam int TsWidth            = 32;

  typedef logic [$clog2(NumChannelsDefault)-1:0] ch_id_t;

  typedef struct packed {
`ifdef SCMI_DB_TIMESTAMP_EN
    logic [TsWidth-1:0] ts;
`endif
    ch_id_t             id;
  } db_evt_t;

endpackage

// File: rtl/scmi_db_fifo.sv
// Registered synchronous FIFO of doorbell events with flush and push-through-pop.
// Pointers carry one extra wrap bit to tell full from empty.
module scmi_db_fifo
  import scmi_db_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    flush_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  db_evt_t wdata_i,
  output db_evt_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AddrW = $clog2(Depth);
  localparam int PtrW  = AddrW + 1;
  localparam logic [PtrW-1:0] PtrOne = {{(PtrW-1){1'b0}}, 1'b1};

  logic [PtrW-1:0] wptr_r;
  logic [PtrW-1:0] rptr_r;
  db_evt_t         mem_r [Depth];
  logic            do_push_s;
  logic            do_pop_s;

  assign empty_o   = (wptr_r == rptr_r);
  assign full_o    = (wptr_r[AddrW] != rptr_r[AddrW]) &&
                     (wptr_r[AddrW-1:0] == rptr_r[AddrW-1:0]);
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign rdata_o   = empty_o ? '0 : mem_r[rptr_r[AddrW-1:0]];

  // Pointer and storage update; flush only rewinds the pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wptr_r[AddrW-1:0]] <= wdata_i;
        wptr_r <= wptr_r + PtrOne;
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + PtrOne;
      end
    end
  end

endmodule

// File: rtl/scmi_db_event_queue.sv
// SCMI doorbell edge detector, per-channel pending set and event FIFO towards the PMS core.
// Optional feature macro: SCMI_DB_TIMESTAMP_EN (adds evt_ts_o and a free-running cycle counter).
module scmi_db_event_queue
  import scmi_db_pkg::*;
#(
  parameter  int NumChannels = NumChannelsDefault,
  parameter  int FifoDepth   = 8,
  localparam int IdWidth     = $clog2(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] db_irq_i,
  input  logic [NumChannels-1:0] db_mask_i,
  input  logic                   flush_i,
  output logic                   evt_valid_o,
  output logic [IdWidth-1:0]     evt_id_o,
  input  logic                   evt_ready_i,
  output logic                   irq_o,
  output logic [NumChannels-1:0] pending_o,
  output logic                   ovf_o,
  output logic [7:0]             ovf_cnt_o
`ifdef SCMI_DB_TIMESTAMP_EN
  ,
  output logic [31:0]            evt_ts_o
`endif
);

  localparam logic [NumChannels-1:0] OneHot0 = {{(NumChannels-1){1'b0}}, 1'b1};
  localparam logic [OvfCntWidth-1:0] CntOne  = {{(OvfCntWidth-1){1'b0}}, 1'b1};

  logic [NumChannels-1:0] db_q_r;
  logic [NumChannels-1:0] pending_r;
  logic [NumChannels-1:0] rise_s;
  logic [NumChannels-1:0] clr_s;
  logic [IdWidth-1:0]     sel_s;
  logic                   push_s;
  logic                   ovf_hit_s;
  logic                   ovf_r;
  logic [OvfCntWidth-1:0] ovf_cnt_r;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  db_evt_t                wr_evt_s;
  db_evt_t                head_evt_s;
`ifdef SCMI_DB_TIMESTAMP_EN
  logic [TsWidth-1:0]     ts_r;
`endif

  assign rise_s = db_irq_i & ~db_q_r & db_mask_i;

  // Lowest-index pending channel owns the push slot this cycle.
  always_comb begin
    sel_s = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (pending_r[i]) begin
        sel_s = IdWidth'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // A full FIFO still accepts a push when its head is popped in the same cycle.
  assign push_s    = (|pending_r) & (~fifo_full_s | evt_ready_i);
  assign clr_s     = push_s ? (OneHot0 << sel_s) : '0;
  assign ovf_hit_s = |(rise_s & pending_r & ~clr_s);

  // Event written to the FIFO tail.
  always_comb begin
    wr_evt_s    = '0;
    wr_evt_s.id = ch_id_t'(sel_s);
`ifdef SCMI_DB_TIMESTAMP_EN
    wr_evt_s.ts = ts_r;
`endif
  end

  // Doorbell history, pending set and sticky overflow tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_q_r    <= '0;
      pending_r <= '0;
      ovf_r     <= 1'b0;
      ovf_cnt_r <= '0;
    end else begin
      db_q_r <= db_irq_i;
      if (flush_i) begin
        pending_r <= '0;
        ovf_r     <= 1'b0;
        ovf_cnt_r <= '0;
      end else begin
        pending_r <= (pending_r & ~clr_s) | rise_s;
        if (ovf_hit_s) begin
          ovf_r <= 1'b1;
          if (ovf_cnt_r != {OvfCntWidth{1'b1}}) begin
            ovf_cnt_r <= ovf_cnt_r + CntOne;
          end
        end
      end
    end
  end

`ifdef SCMI_DB_TIMESTAMP_EN
  // Free-running cycle counter; deliberately untouched by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + 32'd1;
    end
  end

  assign evt_ts_o = head_evt_s.ts;
`endif

  scmi_db_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push_s),
    .pop_i   (evt_ready_i),
    .wdata_i (wr_evt_s),
    .rdata_o (head_evt_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign evt_valid_o = ~fifo_empty_s;
  assign irq_o       = ~fifo_empty_s;
  assign evt_id_o    = head_evt_s.id[IdWidth-1:0];
  assign pending_o   = pending_r;
  assign ovf_o       = ovf_r;
  assign ovf_cnt_o   = ovf_cnt_r;

endmodule

// File: tb/tb_scmi_db_event_queue.sv
// Directed bench for scmi_db_event_queue: queue-based reference model checked every cycle
// plus hand-computed expectations at the interesting points of each scenario.
module tb_scmi_db_event_queue;

  localparam int NCH   = 256;
  localparam int DEPTH = 8;

  logic           clk_i       = 1'b0;
  logic           rst_ni      = 1'b1;
  logic [NCH-1:0] db_irq_i    = '0;
  logic [NCH-1:0] db_mask_i   = '1;
  logic           flush_i     = 1'b0;
  logic           evt_ready_i = 1'b0;
  logic           evt_valid_o;
  logic [7:0]     evt_id_o;
  logic           irq_o;
  logic [NCH-1:0] pending_o;
  logic           ovf_o;
  logic [7:0]     ovf_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  scmi_db_event_queue #(.NumChannels(NCH), .FifoDepth(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .db_irq_i    (db_irq_i),
    .db_mask_i   (db_mask_i),
    .flush_i     (flush_i),
    .evt_valid_o (evt_valid_o),
    .evt_id_o    (evt_id_o),
    .evt_ready_i (evt_ready_i),
    .irq_o       (irq_o),
    .pending_o   (pending_o),
    .ovf_o       (ovf_o),
    .ovf_cnt_o   (ovf_cnt_o)
  );

  task automatic chk_b(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_v(string name, logic [NCH-1:0] act, logic [NCH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a set of pending channels and a bounded queue of channel IDs.
  logic [NCH-1:0] m_pend = '0;
  logic [NCH-1:0] m_prev = '0;
  int             m_q[$];
  bit             m_ovf  = 1'b0;
  int             m_cnt  = 0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_pend = '0;
      m_prev = '0;
      m_q.delete();
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end else if (flush_i) begin
      m_pend = '0;
      m_q.delete();
      m_ovf  = 1'b0;
      m_cnt  = 0;
      m_prev = db_irq_i;
    end else begin
      int lo;
      bit hit;
      lo  = -1;
      hit = 1'b0;
      if (m_q.size() > 0 && evt_ready_i) void'(m_q.pop_front());
      for (int i = NCH - 1; i >= 0; i--) if (m_pend[i]) lo = i;
      if (lo >= 0 && m_q.size() < DEPTH) begin
        m_q.push_back(lo);
        m_pend[lo] = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (db_irq_i[i] && !m_prev[i] && db_mask_i[i]) begin
          if (m_pend[i]) hit = 1'b1;
          m_pend[i] = 1'b1;
        end
      end
      if (hit) begin
        m_ovf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
      m_prev = db_irq_i;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk_b("m_valid", evt_valid_o, m_q.size() > 0);
      chk_b("m_irq", irq_o, m_q.size() > 0);
      if (m_q.size() > 0) chk_i("m_id", int'(evt_id_o), m_q[0]);
      chk_v("m_pending", pending_o, m_pend);
      chk_b("m_ovf", ovf_o, m_ovf);
      chk_i("m_ovf_cnt", int'(ovf_cnt_o), m_cnt);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic pop_expect(int id);
    chk_b("pop_valid", evt_valid_o, 1'b1);
    chk_i("pop_id", int'(evt_id_o), id);
    evt_ready_i = 1'b1;
    step();
    evt_ready_i = 1'b0;
  endtask

  task automatic chk_idle(string name);
    chk_b({name, "_valid"}, evt_valid_o, 1'b0);
    chk_b({name, "_irq"}, irq_o, 1'b0);
    chk_i({name, "_id"}, int'(evt_id_o), 0);
    chk_v({name, "_pending"}, pending_o, '0);
    chk_b({name, "_ovf"}, ovf_o, 1'b0);
    chk_i({name, "_ovf_cnt"}, int'(ovf_cnt_o), 0);
  endtask

  initial begin
    logic [NCH-1:0] exp_v;
    #1 rst_ni = 1'b0;
    step(2);
    chk_idle("reset");
    rst_ni = 1'b1;
    step(2);

    // Single ring held for 100 cycles: one event, visible two cycles after the edge.
    db_irq_i[0] = 1'b1;
    step();
    chk_v("ring_pend", pending_o, 256'h1);
    chk_b("ring_valid_n1", evt_valid_o, 1'b0);
    step();
    chk_b("ring_valid_n2", evt_valid_o, 1'b1);
    chk_i("ring_id", int'(evt_id_o), 0);
    step(98);
    db_irq_i[0] = 1'b0;
    step(3);
    pop_expect(0);
    chk_b("ring_irq_after_pop", irq_o, 1'b0);

    // Cumulative rings 0x1, 0x3, 0x7.
    db_irq_i = 256'h1; step(100);
    db_irq_i = 256'h3; step(100);
    db_irq_i = 256'h7; step(100);
    db_irq_i = '0;     step(2);
    pop_expect(0); pop_expect(1); pop_expect(2);
    chk_b("b2b_empty", evt_valid_o, 1'b0);
    chk_b("b2b_no_ovf", ovf_o, 1'b0);

    // Simultaneous edges on 5, 3, 200 drain lowest first, one per cycle.
    exp_v = '0; exp_v[3] = 1'b1; exp_v[5] = 1'b1; exp_v[200] = 1'b1;
    db_irq_i = exp_v;
    step();
    chk_v("sim_pend0", pending_o, exp_v);
    step();
    exp_v[3] = 1'b0;
    chk_v("sim_pend1", pending_o, exp_v);
    step();
    exp_v[5] = 1'b0;
    chk_v("sim_pend2", pending_o, exp_v);
    step();
    chk_v("sim_pend3", pending_o, '0);
    pop_expect(3); pop_expect(5); pop_expect(200);
    db_irq_i = '0;
    step(2);

    // FIFO full: channels 0..9, only 8 fit; two pops let 8 and 9 in.
    db_irq_i = 256'h3FF;
    step(12);
    chk_v("full_pend", pending_o, 256'h300);
    pop_expect(0); pop_expect(1);
    step(3);
    chk_v("full_pend_drained", pending_o, '0);
    for (int i = 2; i < 10; i++) pop_expect(i);
    chk_b("full_empty", evt_valid_o, 1'b0);
    db_irq_i = '0;
    step(2);

    // Overflow while full, saturation, single id-4 entry, then flush.
    db_irq_i = 256'hFF;
    step(12);
    db_irq_i[4] = 1'b0; step();
    db_irq_i[4] = 1'b1; step();
    chk_v("ovf_pend4", pending_o, 256'h10);
    chk_b("ovf_not_yet", ovf_o, 1'b0);
    db_irq_i[4] = 1'b0; step();
    db_irq_i[4] = 1'b1; step();
    chk_b("ovf_set", ovf_o, 1'b1);
    chk_i("ovf_cnt1", int'(ovf_cnt_o), 1);
    repeat (260) begin
      db_irq_i[4] = 1'b0; step();
      db_irq_i[4] = 1'b1; step();
    end
    chk_i("ovf_sat", int'(ovf_cnt_o), 255);
    for (int i = 0; i < 8; i++) pop_expect(i);
    pop_expect(4);
    chk_b("ovf_one_entry", evt_valid_o, 1'b0);
    chk_b("ovf_sticky", ovf_o, 1'b1);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk_idle("flush");
    db_irq_i = '0;
    step(2);

    // Masked channel 7 produces nothing.
    db_mask_i[7] = 1'b0;
    db_irq_i[7]  = 1'b1;
    step(4);
    chk_b("mask_valid", evt_valid_o, 1'b0);
    chk_v("mask_pend", pending_o, '0);
    db_irq_i[7]  = 1'b0;
    db_mask_i[7] = 1'b1;
    step(2);

    // Asynchronous reset mid-queue; lines still high at release count as edges.
    db_irq_i = 256'h6;
    step(5);
    #2 rst_ni = 1'b0;
    #1;
    chk_idle("async_rst");
    step();
    rst_ni = 1'b1;
    step();
    chk_v("rst_release_pend", pending_o, 256'h6);
    step();
    chk_b("rst_release_valid", evt_valid_o, 1'b1);
    chk_i("rst_release_id", int'(evt_id_o), 1);
    db_irq_i = '0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
